// File: rtl/piso_pkg.sv
// Shared definitions for the piso_shift_tx transmitter: state encoding
// and the bit-counter width helper.
package piso_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SHIFT  = ST_SHIFT,
    PARITY = ST_PARITY
  } state_t;

  // Counter must hold 0..N, so it needs clog2(N+1) bits.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/piso_shift_tx_bit_counter.sv
// Beat counter for piso_shift_tx: synchronous clear, saturating increment
// gated by enable, and a terminal flag when the count reaches N-1.
module bit_counter
  import piso_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = cnt_w(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          terminal
);

  localparam logic [CW-1:0] TERM = CW'(N - 1);

  assign terminal = (count == TERM);

  // Clear has priority; increment stops at N-1 so the count never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (enable) begin
      if (clear) begin
        count <= '0;
      end else if (inc && !terminal) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter with valid/ready load side and
// S_valid/S_last framing on the serial side.
// Optional feature: define PIPO_PARITY_EN to append an even-parity beat.
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] S_in,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         S_out,
  output logic         S_valid,
  output logic         S_last,
  output logic         busy
);

  localparam int            CW      = cnt_w(N);
  localparam logic [CW-1:0] PEN_IDX = CW'(N - 2);
`ifdef PIPO_PARITY_EN
  localparam bit HAS_PARITY = 1'b1;
`else
  localparam bit HAS_PARITY = 1'b0;
`endif

  state_t          state;
  logic [N-1:0]    shift_reg;
  logic [CW-1:0]   count;
  logic            terminal;
  logic            accept;
  logic            load_first;
  logic [N-1:0]    load_rest;
  logic            shift_first;
  logic [N-1:0]    shift_rest;
`ifdef PIPO_PARITY_EN
  logic            parity_reg;
`endif

  // S_last marks the final beat of the frame, so it doubles as the
  // "final beat on S_out" condition for back-to-back loading.
  assign load_ready = enable & ((state == IDLE) | S_last);
  assign accept     = load_valid & load_ready;

  // Bit order: pick the first bit and the remaining word per MSB_FIRST.
  generate
    if (MSB_FIRST) begin : g_msb
      assign load_first  = S_in[N-1];
      assign load_rest   = S_in << 1;
      assign shift_first = shift_reg[N-1];
      assign shift_rest  = shift_reg << 1;
    end else begin : g_lsb
      assign load_first  = S_in[0];
      assign load_rest   = S_in >> 1;
      assign shift_first = shift_reg[0];
      assign shift_rest  = shift_reg >> 1;
    end
  endgenerate

  // count indexes the data beat currently on S_out; it is zeroed whenever
  // a new frame may start so an accept always begins at beat 0.
  bit_counter #(.N(N), .CW(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .clear    ((state != SHIFT) | S_last),
    .inc      (state == SHIFT),
    .count    (count),
    .terminal (terminal)
  );

  // Frame FSM with registered serial outputs; everything holds when enable=0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      S_out     <= 1'b0;
      S_valid   <= 1'b0;
      S_last    <= 1'b0;
      busy      <= 1'b0;
`ifdef PIPO_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else if (enable) begin
      if (accept) begin
        // New frame: first bit goes out immediately, the rest is kept.
        state     <= SHIFT;
        shift_reg <= load_rest;
        S_out     <= load_first;
        S_valid   <= 1'b1;
        S_last    <= 1'b0;
        busy      <= 1'b1;
`ifdef PIPO_PARITY_EN
        parity_reg <= ^S_in;
`endif
      end else begin
        case (state)
          SHIFT: begin
            if (!terminal) begin
              shift_reg <= shift_rest;
              S_out     <= shift_first;
              S_last    <= !HAS_PARITY && (count == PEN_IDX);
            end else begin
`ifdef PIPO_PARITY_EN
              state  <= PARITY;
              S_out  <= parity_reg;
              S_last <= 1'b1;
`else
              state   <= IDLE;
              S_out   <= 1'b0;
              S_valid <= 1'b0;
              S_last  <= 1'b0;
              busy    <= 1'b0;
`endif
            end
          end
          PARITY: begin
            state   <= IDLE;
            S_out   <= 1'b0;
            S_valid <= 1'b0;
            S_last  <= 1'b0;
            busy    <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx (N=4). A scoreboard queue holds the
// expected serial beats; a monitor pops one per enabled clock with S_valid=1.
// Expectations follow PIPO_PARITY_EN when the bench is built with it.
module tb_piso_shift_tx;

  localparam int N = 4;
`ifdef PIPO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int L = N + (PAR ? 1 : 0);

  typedef struct {
    logic b;
    logic last;
  } beat_t;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [N-1:0] S_in;
  logic         load_valid;
  logic         load_ready;
  logic         S_out, S_valid, S_last, busy;

  logic [N-1:0] s_in2;
  logic         load_valid2;
  logic         load_ready2;
  logic         s_out2, s_valid2, s_last2, busy2;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  piso_shift_tx #(.N(N), .MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .S_in       (S_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .S_out      (S_out),
    .S_valid    (S_valid),
    .S_last     (S_last),
    .busy       (busy)
  );

  piso_shift_tx #(.N(N), .MSB_FIRST(1'b0)) dut_lsb (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .S_in       (s_in2),
    .load_valid (load_valid2),
    .load_ready (load_ready2),
    .S_out      (s_out2),
    .S_valid    (s_valid2),
    .S_last     (s_last2),
    .busy       (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected beat i of word w: data bits in the chosen order, then parity.
  function automatic logic exp_bit(input logic [N-1:0] w, input bit msb, input int i);
    if (i >= N) return ^w;
    return msb ? w[N-1-i] : w[i];
  endfunction

  // Drive a word with load_valid; the bench schedules this only when the
  // transmitter should be ready. load_valid stays high on return.
  task automatic send(input logic [N-1:0] w);
    beat_t e;
    S_in       = w;
    load_valid = 1'b1;
    #1;
    check("load_ready_at_send", load_ready, 1'b1);
    @(posedge clk);
    for (int i = 0; i < L; i++) begin
      e.b    = exp_bit(w, 1'b1, i);
      e.last = (i == L - 1);
      sb.push_back(e);
    end
    $display("send word %b (%0d beats queued)", w, L);
    @(negedge clk);
  endtask

  // Monitor: a beat is consumed at each rising edge where enable=1.
  always @(negedge clk) begin
    beat_t e;
    #1;
    if (enable && reset) begin
      if (S_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_beat_S_valid", S_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          $display("beat S_out=%b S_last=%b (exp %b/%b)", S_out, S_last, e.b, e.last);
          check("S_out", S_out, e.b);
          check("S_last", S_last, e.last);
          check("busy_in_frame", busy, 1'b1);
        end
      end else begin
        if (sb.size() != 0) check("missing_beat_S_valid", S_valid, 1'b1);
        check("idle_S_out", S_out, 1'b0);
        check("idle_S_last", S_last, 1'b0);
        check("idle_busy", busy, 1'b0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    enable      = 1'b1;
    S_in        = '0;
    load_valid  = 1'b0;
    s_in2       = '0;
    load_valid2 = 1'b0;

    // Reset state
    #1;
    check("rst_S_out", S_out, 1'b0);
    check("rst_S_valid", S_valid, 1'b0);
    check("rst_S_last", S_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_load_ready", load_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Single frame 1100
    @(negedge clk);
    send(4'b1100);
    load_valid = 1'b0;
    repeat (L) @(negedge clk);
    #1;
    check("t2_idle_S_valid", S_valid, 1'b0);
    check("t2_idle_busy", busy, 1'b0);
    check("t2_drained", sb.size(), 0);

    // Back-to-back 1011 then 0110, load_valid held throughout
    @(negedge clk);
    send(4'b1011);
    repeat (L - 1) @(negedge clk);
    send(4'b0110);
    load_valid = 1'b0;
    repeat (L) @(negedge clk);
    #1;
    check("t3_idle_S_valid", S_valid, 1'b0);
    check("t3_drained", sb.size(), 0);

    // enable=0 for 3 cycles after the second bit of 1100
    @(negedge clk);
    send(4'b1100);
    load_valid = 1'b0;
    @(negedge clk);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      $display("freeze cycle %0d S_out=%b load_ready=%b", k, S_out, load_ready);
      check("freeze_S_out", S_out, 1'b1);
      check("freeze_S_valid", S_valid, 1'b1);
      check("freeze_load_ready", load_ready, 1'b0);
      @(negedge clk);
    end
    enable = 1'b1;
    repeat (L + 1) @(negedge clk);
    #1;
    check("t4_drained", sb.size(), 0);

    // LSB-first instance, 1100 -> 0,0,1,1
    @(negedge clk);
    s_in2       = 4'b1100;
    load_valid2 = 1'b1;
    #1;
    check("lsb_load_ready", load_ready2, 1'b1);
    @(negedge clk);
    load_valid2 = 1'b0;
    s_in2       = 4'b0000;
    for (int i = 0; i < L; i++) begin
      #1;
      $display("lsb beat %0d S_out=%b S_last=%b", i, s_out2, s_last2);
      check("lsb_S_out", s_out2, exp_bit(4'b1100, 1'b0, i));
      check("lsb_S_valid", s_valid2, 1'b1);
      check("lsb_S_last", s_last2, (i == L - 1));
      @(negedge clk);
    end
    #1;
    check("lsb_idle_S_valid", s_valid2, 1'b0);
    check("lsb_idle_busy", busy2, 1'b0);

    // Asynchronous reset in the middle of a frame
    @(negedge clk);
    send(4'b1011);
    load_valid = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    sb.delete();
    #1;
    $display("mid-frame reset S_out=%b S_valid=%b busy=%b", S_out, S_valid, busy);
    check("async_rst_S_out", S_out, 1'b0);
    check("async_rst_S_valid", S_valid, 1'b0);
    check("async_rst_S_last", S_last, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_load_ready", load_ready, enable);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("post_rst_S_valid", S_valid, 1'b0);

    // Frame after reset still works
    @(negedge clk);
    send(4'b0110);
    load_valid = 1'b0;
    repeat (L + 1) @(negedge clk);
    #1;
    check("final_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
